// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. It reads one instruction word per request from
// instruction memory using a req/ack handshake, holds the word in an
// instruction register, and hands it to decode with a valid/ready handshake.
// A flush drops any in-flight or held word. A watchdog aborts requests that
// are never acknowledged and raises a sticky error flag.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 6,
  parameter int INSTR_WIDTH = 16,
  parameter int TIMEOUT     = 15   // 1..255
) (
  input  logic                   clk,
  input  logic                   reset,        // asynchronous, active-low
  input  logic                   fetch_en,
  input  logic [ADDR_WIDTH-1:0]  pc_addr,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]  ir_addr,
  output logic                   fetch_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no request outstanding, IR empty
    S_WAIT = 2'd1,  // request outstanding, waiting for mem_ack
    S_FULL = 2'd2   // IR holds a word for decode
  } state_t;

  // The watchdog aborts in the cycle where it holds this value without an ack.
  // That keeps mem_req high for exactly TIMEOUT cycles.
  localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

  state_t                 state_q,       state_d;
  logic                   mem_req_q,     mem_req_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q,    mem_addr_d;
  logic                   ir_valid_q,    ir_valid_d;
  logic [INSTR_WIDTH-1:0] instr_q,       instr_d;
  logic [ADDR_WIDTH-1:0]  ir_addr_q,     ir_addr_d;
  logic                   fetch_error_q, fetch_error_d;
  logic [7:0]             wdog_q,        wdog_d;
  logic                   discard_q,     discard_d;

  // Next-state and datapath decisions for the fetch FSM.
  always_comb begin
    // NOTE: every signal assigned in this block first gets its hold value.
    // Without that default, a path that skips an assignment infers a latch.
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    ir_valid_d    = ir_valid_q;
    instr_d       = instr_q;
    ir_addr_d     = ir_addr_q;
    fetch_error_d = fetch_error_q;
    wdog_d        = wdog_q;
    discard_d     = discard_q;

    unique case (state_q)
      S_IDLE: begin
        if (fetch_en && !flush) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_addr;
          wdog_d     = '0;
          state_d    = S_WAIT;
        end
      end

      S_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          discard_d = 1'b0;
          if (!flush && !discard_q) begin
            instr_d    = mem_rdata;
            ir_addr_d  = mem_addr_q;
            ir_valid_d = 1'b1;
            state_d    = S_FULL;
          end else begin
            // The word belongs to a flushed path, so it is dropped.
            state_d = S_IDLE;
          end
        end else begin
          // A flush without an ack cannot drop the request, because the
          // memory handshake must complete. Instead, remember to drop the data.
          if (flush) begin
            discard_d = 1'b1;
          end
          if (wdog_q >= WDOG_LIMIT) begin
            mem_req_d     = 1'b0;
            fetch_error_d = 1'b1;
            discard_d     = 1'b0;
            state_d       = S_IDLE;
          end else if (wdog_q != 8'hFF) begin
            wdog_d = wdog_q + 8'd1;
          end
        end
      end

      S_FULL: begin
        if (flush) begin
          ir_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          if (fetch_en) begin
            // Back-to-back issue: the next request starts on the consume edge.
            mem_req_d  = 1'b1;
            mem_addr_d = pc_addr;
            wdog_d     = '0;
            state_d    = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      ir_valid_q    <= 1'b0;
      instr_q       <= '0;
      ir_addr_q     <= '0;
      fetch_error_q <= 1'b0;
      wdog_q        <= '0;
      discard_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge
      // inputs, so the order of these lines does not matter.
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      ir_valid_q    <= ir_valid_d;
      instr_q       <= instr_d;
      ir_addr_q     <= ir_addr_d;
      fetch_error_q <= fetch_error_d;
      wdog_q        <= wdog_d;
      discard_q     <= discard_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign ir_valid    = ir_valid_q;
  assign instruction = instr_q;
  assign ir_addr     = ir_addr_q;
  assign fetch_error = fetch_error_q;

endmodule
